// File: rtl/fpu_dp_div_seq.sv
// Sequential binary64 divider: q = opa * (1/opb), reciprocal and multiply run as registered multicycle stages.
// Optional IEEE special-case handling (NaN/inf/zero operands) is built only when FPU_DIV_SPECIAL_EN is defined.
module fpu_dp_div_seq #(
    parameter int WIDTH        = 64,
    parameter int RECIP_CYCLES = 4,
    parameter int MULT_CYCLES  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             div_by_zero,
    output logic             invalid,
    output logic             busy,
    output logic [1:0]       dbgState
);

    // Handshake: an op is accepted on a rising edge where in_valid && in_ready; a result is consumed
    // on a rising edge where out_valid && out_ready. out_valid, result and flags hold until consumed.

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RECIP = 2'd1;
    localparam logic [1:0] MULT  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam int CNT_MAX = (RECIP_CYCLES > MULT_CYCLES) ? RECIP_CYCLES : MULT_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] opaR;
    logic [WIDTH-1:0] opbR;
    logic [64:0]      recipR;
    logic [WIDTH-1:0] resultR;
    logic             outValidR;

    // Reciprocal mantissa floor(2^116 / mb); mb in [2^52, 2^53) so the quotient fits in 65 bits.
    // The extra precision keeps the single final rounding within 1 ulp.
    function automatic logic [64:0] recipMant(input logic [52:0] mb);
        logic [53:0] rem;
        logic [64:0] q;
        rem = '0;
        q   = '0;
        for (int i = 0; i < 117; i++) begin
            rem = {rem[52:0], (i == 0)};
            q   = {q[63:0], 1'b0};
            if (rem >= {1'b0, mb}) begin
                rem  = rem - {1'b0, mb};
                q[0] = 1'b1;
            end
        end
        return q;
    endfunction

    // ma * recip lands in (2^115, 2^117); normalise, round to nearest even, rebuild the exponent.
    function automatic logic [63:0] mulQuot(input logic sign, input logic [10:0] ea,
                                            input logic [10:0] eb, input logic [52:0] ma,
                                            input logic [64:0] r);
        logic [116:0] prod;
        logic [52:0]  mant;
        logic         guard;
        logic         sticky;
        logic         up;
        logic [53:0]  mantR;
        logic [12:0]  e;
        logic [51:0]  frac;
        prod = 117'(ma) * 117'(r);
        if (prod[116]) begin
            mant   = prod[116:64];
            guard  = prod[63];
            sticky = |prod[62:0];
            e      = 13'(ea) - 13'(eb) + 13'd1023;
        end else begin
            mant   = prod[115:63];
            guard  = prod[62];
            sticky = |prod[61:0];
            e      = 13'(ea) - 13'(eb) + 13'd1022;
        end
        up    = guard & (sticky | mant[0]);
        mantR = {1'b0, mant} + {53'd0, up};
        if (mantR[53]) begin
            e    = e + 13'd1;
            frac = mantR[52:1];
        end else begin
            frac = mantR[51:0];
        end
        return {sign, e[10:0], frac};
    endfunction

`ifdef FPU_DIV_SPECIAL_EN
    typedef struct packed {
        logic        hit;
        logic        dbz;
        logic        inv;
        logic [63:0] res;
    } specialT;

    specialT spec;
    logic    dbzR;
    logic    invR;

    // Denormals (exp==0) count as zero, so they never reach the numeric path.
    always_comb begin
        logic aZero, bZero, aInf, bInf, aNan, bNan, sgn;
        aZero = (opa[62:52] == 11'd0);
        bZero = (opb[62:52] == 11'd0);
        aInf  = (opa[62:52] == 11'h7FF) && (opa[51:0] == 52'd0);
        bInf  = (opb[62:52] == 11'h7FF) && (opb[51:0] == 52'd0);
        aNan  = (opa[62:52] == 11'h7FF) && (opa[51:0] != 52'd0);
        bNan  = (opb[62:52] == 11'h7FF) && (opb[51:0] != 52'd0);
        sgn   = opa[63] ^ opb[63];
        spec  = '{hit: 1'b1, dbz: 1'b0, inv: 1'b0, res: 64'h7FF8000000000000};
        if (aNan || bNan) begin
            spec.res = 64'h7FF8000000000000;
        end else if ((aZero && bZero) || (aInf && bInf)) begin
            spec.inv = 1'b1;
        end else if (bZero) begin
            spec.dbz = 1'b1;
            spec.res = {sgn, 11'h7FF, 52'd0};
        end else if (aInf) begin
            spec.res = {sgn, 11'h7FF, 52'd0};
        end else if (aZero || bInf) begin
            spec.res = {sgn, 63'd0};
        end else begin
            spec.hit = 1'b0;
        end
    end

    assign div_by_zero = dbzR;
    assign invalid     = invR;
`else
    assign div_by_zero = 1'b0;
    assign invalid     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            opaR      <= '0;
            opbR      <= '0;
            recipR    <= '0;
            resultR   <= '0;
            outValidR <= 1'b0;
`ifdef FPU_DIV_SPECIAL_EN
            dbzR      <= 1'b0;
            invR      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        opaR <= opa;
                        opbR <= opb;
`ifdef FPU_DIV_SPECIAL_EN
                        if (spec.hit) begin
                            resultR   <= spec.res;
                            dbzR      <= spec.dbz;
                            invR      <= spec.inv;
                            outValidR <= 1'b1;
                            state     <= DONE;
                        end else begin
                            state <= RECIP;
                            cnt   <= CNT_W'(RECIP_CYCLES - 1);
                        end
`else
                        state <= RECIP;
                        cnt   <= CNT_W'(RECIP_CYCLES - 1);
`endif
                    end
                end
                RECIP: begin
                    if (cnt == '0) begin
                        recipR <= recipMant({1'b1, opbR[51:0]});
                        state  <= MULT;
                        cnt    <= CNT_W'(MULT_CYCLES - 1);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                MULT: begin
                    if (cnt == '0) begin
                        resultR   <= mulQuot(opaR[63] ^ opbR[63], opaR[62:52], opbR[62:52],
                                             {1'b1, opaR[51:0]}, recipR);
                        outValidR <= 1'b1;
                        state     <= DONE;
`ifdef FPU_DIV_SPECIAL_EN
                        dbzR      <= 1'b0;
                        invR      <= 1'b0;
`endif
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        outValidR <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = rst_n && (state == IDLE);
    assign out_valid = outValidR;
    assign result    = resultR;
    assign busy      = (state != IDLE);
    assign dbgState  = state;

endmodule
